// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/next-PC control for the FD/DE/MW pipeline
module pipe_hazard_ctrl #(
    parameter int          MAX_MEM_WAIT = 15,
    parameter logic [31:0] NOP          = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] de_ir,
    input  logic [31:0] mw_ir,
    input  logic        br_taken,
    input  logic        mw_mem_op,
    input  logic        dmem_ready,
    input  logic        irq,
    input  logic        irq_en,
    output logic        stall_fd,
    output logic        stall_mw,
    output logic        flush_fd,
    output logic        flush_mw,
    output logic [1:0]  pc_sel,
    output logic        trap_take,
    output logic        mem_timeout
);
    localparam int W = $clog2(MAX_MEM_WAIT + 1);
    typedef enum logic [1:0] {RUN, MEM_WAIT, TRAP_FLUSH, ERR} state_t;
    state_t state, state_nx;
    logic [W-1:0] cnt, cnt_nx;
    logic s_fd, s_mw, f_fd, f_mw, take;
    logic [1:0] sel;
    logic mem_stall, load_use, rd_rs1, rd_rs2, unused_bits;
    logic [6:0] op;
    logic [4:0] rd;
    assign unused_bits = ^{NOP, mw_ir[31:12]};
    assign op = de_ir[6:0];
    assign rd = mw_ir[11:7];
    assign rd_rs1 = !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
    assign rd_rs2 = op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011;
    assign load_use = mw_ir[6:0] == 7'b0000011 && rd != 5'd0 &&
                      ((rd_rs1 && de_ir[19:15] == rd) || (rd_rs2 && de_ir[24:20] == rd));
    assign mem_stall = mw_mem_op && !dmem_ready;
    // state and wait counter, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end
    // next state and per-cycle control; the MEM_WAIT release cycle acts like RUN but defers traps
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        s_fd = 1'b0;
        s_mw = 1'b0;
        f_fd = 1'b0;
        f_mw = 1'b0;
        take = 1'b0;
        sel  = 2'b00;
        if (state == ERR) begin
            s_fd = 1'b1;
            s_mw = 1'b1;
        end else if (state == TRAP_FLUSH) begin
            f_fd     = 1'b1;
            state_nx = RUN;
        end else if (mem_stall) begin
            s_fd = 1'b1;
            s_mw = 1'b1;
            if (state == RUN) begin
                state_nx = MEM_WAIT;
                cnt_nx   = W'(1);
            end else if (cnt == W'(MAX_MEM_WAIT)) begin
                state_nx = ERR;
            end else begin
                cnt_nx = cnt + 1'b1;
            end
        end else begin
            state_nx = RUN;
            cnt_nx   = '0;
            if (state == RUN && irq && irq_en) begin
                take     = 1'b1;
                f_fd     = 1'b1;
                f_mw     = 1'b1;
                sel      = 2'b10;
                state_nx = TRAP_FLUSH;
            end else if (load_use) begin
                s_fd = 1'b1;
                f_mw = 1'b1;
            end else if (br_taken) begin
                f_fd = 1'b1;
                sel  = 2'b01;
            end else if (de_ir == 32'h30200073) begin
                f_fd = 1'b1;
                sel  = 2'b11;
            end
        end
    end
    assign stall_fd    = rst & s_fd;
    assign stall_mw    = rst & s_mw;
    assign flush_fd    = rst & f_fd;
    assign flush_mw    = rst & f_mw;
    assign trap_take   = rst & take;
    assign pc_sel      = rst ? sel : 2'b00;
    assign mem_timeout = rst & (state == ERR);
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter MAX_MEM_WAIT, default 15, meaning the maximum consecutive data-memory wait cycles before timeout.
REQ-002 The block SHALL have parameter NOP, default 32'h00000013, meaning the bubble encoding that the downstream register stage inserts on flush.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port de_ir, input, 32 bits: instruction in the DE stage.
REQ-006 The block SHALL have port mw_ir, input, 32 bits: instruction in the MW stage.
REQ-007 The block SHALL have port br_taken, input, 1 bit: branch or jump in DE resolved taken.
REQ-008 The block SHALL have ports mw_mem_op (input, 1 bit, MW holds a load or store) and dmem_ready (input, 1 bit, data memory completes this cycle).
REQ-009 The block SHALL have ports irq (input, 1 bit, level interrupt request) and irq_en (input, 1 bit, global interrupt enable from the CSR file).
REQ-010 The block SHALL have ports stall_fd (output, 1 bit, hold PC and the FD register) and stall_mw (output, 1 bit, hold all DE/MW registers).
REQ-011 The block SHALL have ports flush_fd (output, 1 bit, replace FD contents with NOP) and flush_mw (output, 1 bit, load NOP into DE/MW next edge).
REQ-012 The block SHALL have port pc_sel, output, 2 bits: next-PC source, 00 sequential, 01 branch target, 10 trap vector, 11 mepc.
REQ-013 The block SHALL have ports trap_take (output, 1 bit, one-cycle pulse to the CSR file) and mem_timeout (output, 1 bit, sticky error).

Function
REQ-014 The block SHALL implement an FSM with states RUN, MEM_WAIT, TRAP_FLUSH and ERR, plus a wait counter of width $clog2(MAX_MEM_WAIT+1).
REQ-015 In RUN or MEM_WAIT with mw_mem_op=1 and dmem_ready=0, the block SHALL combinationally assert stall_fd=stall_mw=1, drive pc_sel=00, and suppress every other action.
REQ-016 RUN SHALL go to MEM_WAIT with counter=1 when mw_mem_op=1 and dmem_ready=0.
REQ-017 In MEM_WAIT the counter SHALL increment each cycle with dmem_ready=0.
REQ-018 From MEM_WAIT, dmem_ready=1 SHALL deassert both stalls in that same cycle, clear the counter, and return to RUN.
REQ-019 When the counter equals MAX_MEM_WAIT and dmem_ready=0, the FSM SHALL enter ERR.
REQ-020 ERR SHALL hold stall_fd=stall_mw=1 and mem_timeout=1 and SHALL leave only on reset.
REQ-021 In RUN with no memory stall, irq=1 and irq_en=1, the block SHALL for one cycle assert trap_take=1, flush_fd=1, flush_mw=1 and pc_sel=10, then enter TRAP_FLUSH.
REQ-022 TRAP_FLUSH SHALL last exactly one cycle with flush_fd=1, pc_sel=00 and irq ignored, then return to RUN.
REQ-023 Load-use hazard definition: mw_ir[6:0]=0000011, rd=mw_ir[11:7]!=0, and either de_ir reads rs1 (opcode not LUI/AUIPC/JAL) with rs1==rd, or de_ir reads rs2 (R, S or B opcode) with rs2==rd.
REQ-024 On a load-use hazard in RUN with no memory stall or trap, the block SHALL assert stall_fd=1 and flush_mw=1 for that cycle only, with pc_sel=00 and br_taken ignored.
REQ-025 Otherwise in RUN, br_taken=1 SHALL assert flush_fd=1 with pc_sel=01.
REQ-026 Otherwise in RUN, de_ir==32'h30200073 (mret) SHALL assert flush_fd=1 with pc_sel=11.
REQ-027 RUN priority SHALL be memory stall > trap > load-use > branch > mret > normal, with all outputs 0 in the normal case.
REQ-028 trap_take SHALL never be high for two consecutive cycles.

Reset
REQ-029 While rst=0, the block SHALL force state=RUN, counter=0, mem_timeout=0, and all outputs to 0 (pc_sel=00), asynchronously and regardless of in-flight stall, trap or error.
REQ-030 After rst deasserts, the first rising edge SHALL evaluate RUN rules normally.

Verification
REQ-031 The bench SHALL drive mw_ir=lw x5 and de_ir=add x6,x5,x1 -> stall_fd=1 and flush_mw=1 for exactly 1 cycle; with de_ir rd=x0-only load (lw x0), no stall.
REQ-032 The bench SHALL drive mw_mem_op=1 with dmem_ready low 3 cycles then high -> stalls high for 3 cycles, low on the ready cycle, FSM back in RUN.
REQ-033 The bench SHALL hold dmem_ready low with MAX_MEM_WAIT=4 -> ERR after 4 wait cycles, mem_timeout=1 and stalls stuck until rst=0.
REQ-034 The bench SHALL drive irq=1, irq_en=1 and br_taken=1 together -> trap wins: trap_take one pulse, pc_sel=10, then one TRAP_FLUSH cycle, no second pulse while irq held.
REQ-035 The bench SHALL drive a load-use hazard with br_taken=1 in the same cycle -> pc_sel=00 in that cycle, pc_sel=01 in the following cycle.
REQ-036 The bench SHALL pull rst low during MEM_WAIT -> all outputs 0 immediately and counter cleared.
